// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide controller.
//   op_e      - operation select encodings driven on muldiv_ctrl.op
//   state_e   - controller FSM states
//   Lat*      - rising edges from the accepting edge (counted as edge 1) to DONE
//   is_*_op   - op classification helpers
package muldiv_pkg;

    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpDiv   = 3'd2,
        OpDivu  = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } state_e;

    // MTHI/MTLO: DONE on the accepting edge itself.
    localparam int unsigned LatMt        = 1;
    // Combinational multiply: one MUL cycle, DONE on the following edge.
    localparam int unsigned LatMulComb   = 2;
    // Iterative paths: DW iteration cycles, DONE at edge DW + LatIterExtra.
    localparam int unsigned LatIterExtra = 1;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OpMult) || (op == OpMultu);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

    function automatic logic is_mt_op(input logic [2:0] op);
        return (op == OpMthi) || (op == OpMtlo);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

endpackage

// File: rtl/div_core.sv
// div_core: radix-2 restoring divider on operand magnitudes with signed fix-up.
//   clk, resetn  - clock, asynchronous active-low reset
//   i_load       - capture operands and start a new divide
//   i_signed     - operands are two's complement (DIV) rather than unsigned (DIVU)
//   i_a, i_b     - dividend, divisor
//   i_run        - perform one iteration this cycle
//   o_last       - the iteration performed this cycle is the final one
//   o_hi, o_lo   - remainder / quotient including the final iteration (valid with o_last)
// Divide by zero returns HI = dividend, LO = all-ones.
module div_core
    import muldiv_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_load,
    input  logic          i_signed,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_run,
    output logic          o_last,
    output logic [DW-1:0] o_hi,
    output logic [DW-1:0] o_lo
);

    localparam int unsigned    CntW    = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DW - 1);

    logic [CntW-1:0] r_cnt;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_quo;
    logic [DW-1:0]   r_rem;
    logic [DW-1:0]   r_dvs;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_dz;

    logic [DW-1:0]   w_a_mag;
    logic [DW-1:0]   w_b_mag;
    logic [DW:0]     w_shift;
    logic [DW:0]     w_diff;
    logic            w_qbit;
    logic [DW-1:0]   w_rem_nxt;
    logic [DW-1:0]   w_quo_nxt;
    logic [DW-1:0]   w_quo_fix;
    logic [DW-1:0]   w_rem_fix;

    assign w_a_mag = (i_signed && i_a[DW-1]) ? -i_a : i_a;
    assign w_b_mag = (i_signed && i_b[DW-1]) ? -i_b : i_b;

    // Partial remainder is always below the divisor, so DW+1 bits hold the
    // shifted value and the top bit of the difference is the borrow.
    assign w_shift   = {r_rem, r_quo[DW-1]};
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[DW];
    assign w_rem_nxt = w_qbit ? w_diff[DW-1:0] : w_shift[DW-1:0];
    assign w_quo_nxt = {r_quo[DW-2:0], w_qbit};

    // Unsigned 0x8000_0000 / 1 negated stays 0x8000_0000, which is the
    // required result for the most-negative / -1 case.
    assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    assign o_last = (r_cnt == LastCnt);
    assign o_hi   = r_dz ? r_a : w_rem_fix;
    assign o_lo   = r_dz ? {DW{1'b1}} : w_quo_fix;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else if (i_load) begin
            r_cnt   <= '0;
            r_a     <= i_a;
            r_quo   <= w_a_mag;
            r_rem   <= '0;
            r_dvs   <= w_b_mag;
            r_neg_q <= i_signed && (i_a[DW-1] ^ i_b[DW-1]);
            r_neg_r <= i_signed && i_a[DW-1];
            r_dz    <= (i_b == '0);
        end else if (i_run) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= o_last ? '0 : r_cnt + CntW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide controller with pipeline stall and flush.
//   clk, resetn          - clock, asynchronous active-low reset
//   start, op            - request pulse and operation (muldiv_pkg::op_e), sampled in IDLE
//   src_a, src_b         - operands, captured when start is accepted
//   hi_in, lo_in         - current HI/LO, preserve the untouched half on MTHI/MTLO
//   cancel               - flush; aborts any operation in flight, wins over start
//   stall                - pipeline hold request
//   busy                 - FSM not in IDLE
//   hilo_wen, hilo_wdata - HI/LO write, HI in upper DW bits, LO in lower DW bits
// Build option MULDIV_ITER_MUL_EN: when defined, MULT/MULTU use a DW-cycle
// shift-add sequence; otherwise a single-cycle combinational multiplier.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [DW-1:0]   src_a,
    input  logic [DW-1:0]   src_b,
    input  logic [DW-1:0]   hi_in,
    input  logic [DW-1:0]   lo_in,
    input  logic            cancel,
    output logic            stall,
    output logic            busy,
    output logic            hilo_wen,
    output logic [2*DW-1:0] hilo_wdata
);

    state_e          r_state;
    state_e          w_state_next;
    logic [2*DW-1:0] r_hilo;

    logic            w_accept;
    logic            w_sgn;
    logic            w_mul_last;
    logic [2*DW-1:0] w_mul_res;
    logic            w_div_last;
    logic [DW-1:0]   w_div_hi;
    logic [DW-1:0]   w_div_lo;

    assign w_accept = (r_state == StIdle) && start && !cancel &&
                      (is_mul_op(op) || is_div_op(op) || is_mt_op(op));
    assign w_sgn    = is_signed_op(op);

    div_core #(
        .DW (DW)
    ) u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .i_load   (w_accept && is_div_op(op)),
        .i_signed (w_sgn),
        .i_a      (src_a),
        .i_b      (src_b),
        .i_run    ((r_state == StDiv) && !cancel),
        .o_last   (w_div_last),
        .o_hi     (w_div_hi),
        .o_lo     (w_div_lo)
    );

`ifdef MULDIV_ITER_MUL_EN
    localparam int unsigned    CntW    = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DW - 1);

    logic [2*DW-1:0] r_mcand;
    logic [2*DW-1:0] r_acc;
    logic [DW-1:0]   r_mplier;
    logic            r_mneg;
    logic [CntW-1:0] r_mcnt;
    logic [DW-1:0]   w_a_mag;
    logic [DW-1:0]   w_b_mag;
    logic [2*DW-1:0] w_acc_nxt;

    assign w_a_mag    = (w_sgn && src_a[DW-1]) ? -src_a : src_a;
    assign w_b_mag    = (w_sgn && src_b[DW-1]) ? -src_b : src_b;
    assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_last = (r_mcnt == LastCnt);
    // Final add and sign fix-up happen in the last MUL cycle so the result
    // lands in r_hilo on the edge that enters DONE.
    assign w_mul_res  = r_mneg ? -w_acc_nxt : w_acc_nxt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_mneg   <= 1'b0;
            r_mcnt   <= '0;
        end else if (w_accept && is_mul_op(op)) begin
            r_mcand  <= {{DW{1'b0}}, w_a_mag};
            r_acc    <= '0;
            r_mplier <= w_b_mag;
            r_mneg   <= w_sgn && (src_a[DW-1] ^ src_b[DW-1]);
            r_mcnt   <= '0;
        end else if ((r_state == StMul) && !cancel) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= {r_mcand[2*DW-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[DW-1:1]};
            r_mcnt   <= w_mul_last ? '0 : r_mcnt + CntW'(1);
        end else begin
            r_mcnt <= '0;
        end
    end
`else
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic            r_msgn;
    logic [2*DW-1:0] w_a_ext;
    logic [2*DW-1:0] w_b_ext;

    // Sign-extending to 2*DW makes the low 2*DW product bits correct for
    // both signed and unsigned operands.
    assign w_a_ext    = {{DW{r_msgn & r_a[DW-1]}}, r_a};
    assign w_b_ext    = {{DW{r_msgn & r_b[DW-1]}}, r_b};
    assign w_mul_res  = w_a_ext * w_b_ext;
    assign w_mul_last = 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a    <= '0;
            r_b    <= '0;
            r_msgn <= 1'b0;
        end else if (w_accept && is_mul_op(op)) begin
            r_a    <= src_a;
            r_b    <= src_b;
            r_msgn <= w_sgn;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != StIdle);
        hilo_wen     = (r_state == StDone) && !cancel;
        // Gated by resetn so a start held during reset raises no stall.
        stall        = resetn && ((start && (r_state == StIdle)) ||
                                  (r_state == StMul) || (r_state == StDiv));
        unique case (r_state)
            StIdle: begin
                if (start && !cancel) begin
                    if (is_mul_op(op)) begin
                        w_state_next = StMul;
                    end else if (is_div_op(op)) begin
                        w_state_next = StDiv;
                    end else if (is_mt_op(op)) begin
                        w_state_next = StDone;
                    end
                end
            end
            StMul: begin
                if (cancel) begin
                    w_state_next = StIdle;
                end else if (w_mul_last) begin
                    w_state_next = StDone;
                end
            end
            StDiv: begin
                if (cancel) begin
                    w_state_next = StIdle;
                end else if (w_div_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Only written on accept or on the edge entering DONE, so the value is
    // stable through the whole DONE cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hilo <= '0;
        end else if (w_accept && (op == OpMthi)) begin
            r_hilo <= {src_a, lo_in};
        end else if (w_accept && (op == OpMtlo)) begin
            r_hilo <= {hi_in, src_a};
        end else if ((r_state == StMul) && !cancel && w_mul_last) begin
            r_hilo <= w_mul_res;
        end else if ((r_state == StDiv) && !cancel && w_div_last) begin
            r_hilo <= {w_div_hi, w_div_lo};
        end
    end

    assign hilo_wdata = r_hilo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

`ifdef MULDIV_ITER_MUL_EN
    localparam int MulLat = 33;
`else
    localparam int MulLat = 2;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        cancel;
    logic        stall;
    logic        busy;
    logic        hilo_wen;
    logic [63:0] hilo_wdata;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(
        .DW (32)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .hi_in      (hi_in),
        .lo_in      (lo_in),
        .cancel     (cancel),
        .stall      (stall),
        .busy       (busy),
        .hilo_wen   (hilo_wen),
        .hilo_wdata (hilo_wdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Edges are numbered from the accepting edge (edge 1). Samples 1 time unit
    // after each edge. poke_at raises a stray MTHI start after that edge.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input int poke_at,
                         output int lat, output logic [63:0] data, output int stall_cnt,
                         output int wen_cnt, output logic stall_done);
        @(negedge clk);
        op = o; src_a = a; src_b = b; hi_in = hi; lo_in = lo; start = 1'b1;
        #1;
        stall_cnt  = stall ? 1 : 0;
        lat        = -1;
        wen_cnt    = 0;
        data       = '0;
        stall_done = 1'b1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) start = 1'b0;
            if (hilo_wen) begin
                wen_cnt++;
                if (lat < 0) begin
                    lat        = e;
                    data       = hilo_wdata;
                    stall_done = stall;
                end
            end else if (lat < 0 && stall) begin
                stall_cnt++;
            end
            if (e == poke_at) begin
                start = 1'b1; op = OpMthi; src_a = 32'hDEAD_BEEF;
            end else if (e == poke_at + 1) begin
                start = 1'b0;
            end
            if (lat >= 0 && e >= lat + 1) break;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                             input int poke_at, input int exp_lat, input logic [63:0] exp_data);
        int          lat;
        logic [63:0] data;
        int          scnt;
        int          wcnt;
        logic        sdone;
        do_op(o, a, b, hi, lo, poke_at, lat, data, scnt, wcnt, sdone);
        check_eq({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, ".data"}, data, exp_data);
        check_eq({tag, ".stall_cycles"}, 64'(scnt), 64'(exp_lat));
        check_eq({tag, ".wen_cycles"}, 64'(wcnt), 64'd1);
        check_eq({tag, ".stall_in_done"}, 64'(sdone), 64'd0);
    endtask

    task automatic count_wen(input int cycles, output int wcnt, output int bcnt);
        wcnt = 0;
        bcnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (hilo_wen) wcnt++;
            if (busy) bcnt++;
        end
    endtask

    int wcnt;
    int bcnt;

    initial begin
        resetn = 1'b0; start = 1'b1; op = OpDiv; cancel = 1'b0;
        src_a = 32'd5; src_b = 32'd1; hi_in = '0; lo_in = '0;
        #12;
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.stall", 64'(stall), 64'd0);
        check_eq("rst.wen", 64'(hilo_wen), 64'd0);
        check_eq("rst.wdata", hilo_wdata, 64'd0);
        @(negedge clk);
        start  = 1'b0;
        resetn = 1'b1;

        run_check("divu_100_7", OpDivu, 32'd100, 32'd7, '0, '0, 5, 33, {32'd2, 32'd14});
        run_check("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, '0, '0, -1, 33,
                  64'hFFFF_FFFF_FFFF_FFFD);
        run_check("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, '0, '0, -1, 33,
                  64'h0000_0000_8000_0000);
        run_check("divu_zero", OpDivu, 32'h0000_1234, 32'd0, '0, '0, -1, 33,
                  64'h0000_1234_FFFF_FFFF);
        run_check("div_zero_neg", OpDiv, 32'hFFFF_FFF9, 32'd0, '0, '0, -1, 33,
                  64'hFFFF_FFF9_FFFF_FFFF);
        run_check("divu_big", OpDivu, 32'hFFFF_FFFF, 32'h10, '0, '0, -1, 33,
                  64'h0000_000F_0FFF_FFFF);
        run_check("mult", OpMult, 32'hFFFF_FFFF, 32'd2, '0, '0, -1, MulLat,
                  64'hFFFF_FFFF_FFFF_FFFE);
        run_check("multu", OpMultu, 32'hFFFF_FFFF, 32'd2, '0, '0, -1, MulLat,
                  64'h0000_0001_FFFF_FFFE);
        run_check("mult_m7_3", OpMult, 32'hFFFF_FFF9, 32'd3, '0, '0, -1, MulLat,
                  64'hFFFF_FFFF_FFFF_FFEB);
        run_check("mtlo", OpMtlo, 32'hA5A5_A5A5, '0, 32'h1111_1111, 32'h2222_2222, 1, 1,
                  64'h1111_1111_A5A5_A5A5);
        run_check("mthi_b2b", OpMthi, 32'hCAFE_F00D, '0, 32'h3333_3333, 32'h4444_4444, -1, 1,
                  64'hCAFE_F00D_4444_4444);

        // Cancel during iteration 10 of a DIV.
        @(negedge clk);
        op = OpDiv; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1;
        check_eq("cancel_div.busy", 64'(busy), 64'd0);
        check_eq("cancel_div.stall", 64'(stall), 64'd0);
        cancel = 1'b0;
        count_wen(40, wcnt, bcnt);
        check_eq("cancel_div.no_wen", 64'(wcnt), 64'd0);

        // Cancel while in DONE suppresses the write.
        @(negedge clk);
        op = OpMtlo; src_a = 32'h5555_5555; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cancel = 1'b1;
        #1;
        check_eq("cancel_done.busy", 64'(busy), 64'd1);
        check_eq("cancel_done.wen", 64'(hilo_wen), 64'd0);
        @(posedge clk);
        #1 cancel = 1'b0;
        check_eq("cancel_done.idle", 64'(busy), 64'd0);

        // Cancel wins over start in IDLE.
        @(negedge clk);
        op = OpMthi; src_a = 32'h7777_7777; start = 1'b1; cancel = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cancel = 1'b0;
        check_eq("cancel_start.busy", 64'(busy), 64'd0);
        count_wen(5, wcnt, bcnt);
        check_eq("cancel_start.no_wen", 64'(wcnt), 64'd0);

        // Reset mid-divide.
        @(negedge clk);
        op = OpDivu; src_a = 32'd999; src_b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check_eq("rst_mid.busy", 64'(busy), 64'd0);
        check_eq("rst_mid.wen", 64'(hilo_wen), 64'd0);
        check_eq("rst_mid.wdata", hilo_wdata, 64'd0);
        start = 1'b1;
        #1;
        check_eq("rst_mid.stall", 64'(stall), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        resetn = 1'b1;
        count_wen(40, wcnt, bcnt);
        check_eq("rst_mid.no_wen", 64'(wcnt), 64'd0);
        check_eq("rst_mid.no_busy", 64'(bcnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
